// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: machine word/line types and the L2 arbiter enums.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;
  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RECOVER = 2'd3
  } l2_arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } l2_arb_req_t;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter putting the L1 I-cache and D-cache miss paths onto the single L2 port.
// One transaction in flight; a RECOVER cycle follows every completion.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  l2_arb_state_t r_state;
  l2_arb_state_t w_next_state;
  l2_arb_req_t   r_last_grant;

  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_i_cnt;
  logic [CNT_W-1:0]  r_d_cnt;

  logic w_req_i;
  logic w_req_d;
  logic w_grant_i;
  logic w_grant_d;

  assign w_req_i = icache_read;
  assign w_req_d = dcache_read | dcache_write;

  // On a tie the requester that did not win last time gets the port.
  assign w_grant_i = (r_state == IDLE) && w_req_i &&
                     (!w_req_d || (r_last_grant == DCACHE));
  assign w_grant_d = (r_state == IDLE) && w_req_d && !w_grant_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_next_state = BUSY_I;
        end else if (w_grant_d) begin
          w_next_state = BUSY_D;
        end
      end
      BUSY_I:  if (l2_resp) w_next_state = RECOVER;
      BUSY_D:  if (l2_resp) w_next_state = RECOVER;
      RECOVER: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction latches and grant counters; held untouched while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= DCACHE;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_cnt      <= '0;
      r_d_cnt      <= '0;
    end else if (w_grant_i) begin
      r_last_grant <= ICACHE;
      r_op_write   <= 1'b0;
      r_addr       <= icache_addr;
      r_wdata      <= '0;
      r_i_cnt      <= r_i_cnt + CNT_W'(1);
    end else if (w_grant_d) begin
      r_last_grant <= DCACHE;
      r_op_write   <= dcache_write;
      r_addr       <= dcache_addr;
      r_wdata      <= dcache_wdata;
      r_d_cnt      <= r_d_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    l2_addr      = '0;
    l2_wdata     = '0;
    icache_resp  = 1'b0;
    icache_rdata = '0;
    dcache_resp  = 1'b0;
    dcache_rdata = '0;
    case (r_state)
      BUSY_I: begin
        l2_read     = 1'b1;
        l2_addr     = r_addr;
        icache_resp = l2_resp;
        if (l2_resp) icache_rdata = l2_rdata;
      end
      BUSY_D: begin
        l2_read     = !r_op_write;
        l2_write    = r_op_write;
        l2_addr     = r_addr;
        l2_wdata    = r_wdata;
        dcache_resp = l2_resp;
        if (l2_resp) dcache_rdata = l2_rdata;
      end
      default: ;
    endcase
  end

  assign i_grant_cnt = r_i_cnt;
  assign d_grant_cnt = r_d_cnt;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed table-driven bench for l2_arbiter, plus hand sequences for latch hold,
// mid-transaction reset and counter wrap (wrap observed on a narrow-counter instance).
module tb_l2_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              icache_read, dcache_read, dcache_write, l2_resp;
  logic [ADDR_W-1:0] icache_addr, dcache_addr;
  logic [LINE_W-1:0] dcache_wdata, l2_rdata;
  logic [LINE_W-1:0] icache_rdata, dcache_rdata, l2_wdata;
  logic              icache_resp, dcache_resp, l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [15:0]       i_grant_cnt, d_grant_cnt;

  logic [LINE_W-1:0] s_irdata, s_drdata, s_wdata;
  logic              s_iresp, s_dresp, s_read, s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]        s_icnt, s_dcnt;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] RD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] WD = {16{8'hA5}};

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_addr(icache_addr),
    .icache_rdata(s_irdata), .icache_resp(s_iresp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_rdata(s_drdata), .dcache_resp(s_dresp),
    .l2_read(s_read), .l2_write(s_write), .l2_addr(s_addr),
    .l2_wdata(s_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_cnt(s_icnt), .d_grant_cnt(s_dcnt)
  );

  typedef struct {
    logic        ir, dr, dw, rsp;
    logic [3:0]  e_cmd;   // {l2_read, l2_write, icache_resp, dcache_resp}
    logic [15:0] e_addr;
    logic [15:0] e_icnt, e_dcnt;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic ir, logic dr, logic dw, logic rsp, logic [3:0] cmd,
                              logic [15:0] a, logic [15:0] ic, logic [15:0] dc);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rsp = rsp;
    v.e_cmd = cmd; v.e_addr = a; v.e_icnt = ic; v.e_dcnt = dc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic d_txn;
    dcache_read = 1'b1;
    tick();
    dcache_read = 1'b0;
    l2_resp = 1'b1;
    #2;
    chk("wrap_dresp", {127'd0, dcache_resp}, 128'd1);
    tick();
    l2_resp = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    icache_read = 1'b1; dcache_read = 1'b0; dcache_write = 1'b0; l2_resp = 1'b0;
    icache_addr = 16'h1110; dcache_addr = 16'h2220;
    dcache_wdata = 128'h5555; l2_rdata = RD;

    vecs[0]  = mk(1,0,0,0, 4'b0000, 16'h0000, 0, 0);
    vecs[1]  = mk(1,0,0,0, 4'b1000, 16'h1110, 1, 0);
    vecs[2]  = mk(1,0,0,0, 4'b1000, 16'h1110, 1, 0);
    vecs[3]  = mk(1,0,0,1, 4'b1010, 16'h1110, 1, 0);
    vecs[4]  = mk(0,0,0,0, 4'b0000, 16'h0000, 1, 0);
    vecs[5]  = mk(0,0,0,0, 4'b0000, 16'h0000, 1, 0);
    vecs[6]  = mk(1,1,0,0, 4'b0000, 16'h0000, 1, 0);
    vecs[7]  = mk(1,1,0,0, 4'b1000, 16'h2220, 1, 1);
    vecs[8]  = mk(1,1,0,1, 4'b1001, 16'h2220, 1, 1);
    vecs[9]  = mk(1,1,0,0, 4'b0000, 16'h0000, 1, 1);
    vecs[10] = mk(1,1,0,0, 4'b0000, 16'h0000, 1, 1);
    vecs[11] = mk(1,1,0,0, 4'b1000, 16'h1110, 2, 1);
    vecs[12] = mk(1,1,0,1, 4'b1010, 16'h1110, 2, 1);
    vecs[13] = mk(1,1,0,0, 4'b0000, 16'h0000, 2, 1);
    vecs[14] = mk(1,1,0,0, 4'b0000, 16'h0000, 2, 1);
    vecs[15] = mk(1,1,0,0, 4'b1000, 16'h2220, 2, 2);
    vecs[16] = mk(1,1,0,1, 4'b1001, 16'h2220, 2, 2);
    vecs[17] = mk(1,1,0,0, 4'b0000, 16'h0000, 2, 2);
    vecs[18] = mk(1,1,0,0, 4'b0000, 16'h0000, 2, 2);
    vecs[19] = mk(1,1,0,0, 4'b1000, 16'h1110, 3, 2);
    vecs[20] = mk(1,1,0,1, 4'b1010, 16'h1110, 3, 2);
    vecs[21] = mk(0,0,0,0, 4'b0000, 16'h0000, 3, 2);
    vecs[22] = mk(0,0,0,1, 4'b0000, 16'h0000, 3, 2);
    vecs[23] = mk(0,0,0,1, 4'b0000, 16'h0000, 3, 2);
    vecs[24] = mk(0,1,1,0, 4'b0000, 16'h0000, 3, 2);
    vecs[25] = mk(0,0,0,0, 4'b0100, 16'h2220, 3, 3);
    vecs[26] = mk(0,0,0,1, 4'b0101, 16'h2220, 3, 3);
    vecs[27] = mk(0,0,0,1, 4'b0000, 16'h0000, 3, 3);
    vecs[28] = mk(0,0,0,0, 4'b0000, 16'h0000, 3, 3);

    // Reset held with an I-cache request pending.
    repeat (3) @(posedge clk);
    #3;
    chk("reset_cmd", {124'd0, l2_read, l2_write, icache_resp, dcache_resp}, 128'd0);
    chk("reset_cnt", {96'd0, i_grant_cnt, d_grant_cnt}, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      icache_read = vecs[k].ir; dcache_read = vecs[k].dr;
      dcache_write = vecs[k].dw; l2_resp = vecs[k].rsp;
      #2;
      chk($sformatf("v%0d_cmd", k), {124'd0, l2_read, l2_write, icache_resp, dcache_resp},
          {124'd0, vecs[k].e_cmd});
      chk($sformatf("v%0d_addr", k), {112'd0, l2_addr}, {112'd0, vecs[k].e_addr});
      chk($sformatf("v%0d_irdata", k), icache_rdata, vecs[k].e_cmd[1] ? RD : 128'd0);
      chk($sformatf("v%0d_drdata", k), dcache_rdata, vecs[k].e_cmd[0] ? RD : 128'd0);
      chk($sformatf("v%0d_cnt", k), {96'd0, i_grant_cnt, d_grant_cnt},
          {96'd0, vecs[k].e_icnt, vecs[k].e_dcnt});
      tick();
    end

    // Writeback: latched address/data must survive requester input changes.
    dcache_write = 1'b1; dcache_addr = 16'h1230; dcache_wdata = WD; l2_resp = 1'b0;
    #2;
    chk("wb_grant_nocmd", {126'd0, l2_read, l2_write}, 128'd0);
    tick();
    dcache_addr = 16'h4560; dcache_wdata = '0; dcache_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      l2_resp = (c == 2);
      #2;
      chk($sformatf("wb_c%0d_cmd", c), {125'd0, l2_read, l2_write, icache_resp},
          {125'd0, 3'b010});
      chk($sformatf("wb_c%0d_addr", c), {112'd0, l2_addr}, {112'd0, 16'h1230});
      chk($sformatf("wb_c%0d_wdata", c), l2_wdata, WD);
      chk($sformatf("wb_c%0d_dresp", c), {127'd0, dcache_resp}, {127'd0, (c == 2)});
      tick();
    end
    l2_resp = 1'b0;
    #2;
    chk("wb_recover", {126'd0, l2_read, l2_write}, 128'd0);
    chk("wb_cnt", {96'd0, i_grant_cnt, d_grant_cnt}, {96'd0, 16'd3, 16'd4});
    tick();

    // Reset asserted in the middle of a D-cache read.
    dcache_addr = 16'h2220;
    dcache_read = 1'b1;
    tick();
    #2;
    chk("mid_busy_read", {127'd0, l2_read}, 128'd1);
    rst_n = 1'b0;
    l2_resp = 1'b1;
    #1;
    chk("arst_cmd", {124'd0, l2_read, l2_write, icache_resp, dcache_resp}, 128'd0);
    chk("arst_addr", {112'd0, l2_addr}, 128'd0);
    chk("arst_drdata", dcache_rdata, 128'd0);
    chk("arst_cnt", {96'd0, i_grant_cnt, d_grant_cnt}, 128'd0);
    tick();
    chk("arst_hold_dresp", {127'd0, dcache_resp}, 128'd0);
    icache_read = 1'b1; dcache_read = 1'b1; l2_resp = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post_rst_idle", {126'd0, l2_read, l2_write}, 128'd0);
    tick();
    #2;
    chk("post_rst_grant_i", {126'd0, l2_read, l2_write}, {126'd0, 2'b10});
    chk("post_rst_addr", {112'd0, l2_addr}, {112'd0, 16'h1110});
    chk("post_rst_cnt", {96'd0, i_grant_cnt, d_grant_cnt}, {96'd0, 16'd1, 16'd0});
    l2_resp = 1'b1;
    #1;
    chk("post_rst_iresp", {126'd0, icache_resp, dcache_resp}, {126'd0, 2'b10});
    tick();
    icache_read = 1'b0; dcache_read = 1'b0; l2_resp = 1'b0;
    tick();

    // Counter wrap: 15 D grants fill the 4-bit counter, the 16th rolls it over.
    for (int n = 0; n < 15; n++) d_txn();
    chk("wrap_full_small", {124'd0, s_dcnt}, {124'd0, 4'hF});
    chk("wrap_full_main", {112'd0, d_grant_cnt}, {112'd0, 16'd15});
    d_txn();
    chk("wrap_zero_small", {124'd0, s_dcnt}, 128'd0);
    chk("wrap_main", {112'd0, d_grant_cnt}, {112'd0, 16'd16});
    chk("wrap_icnt", {108'd0, s_icnt, i_grant_cnt}, {108'd0, 4'd1, 16'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
